// File: rtl/tone_decoder.sv
`default_nettype none
// tone_decoder - locks onto one of four note half-periods on iSOUND and reports note/silence segments (rev 1.0)
// Option: define TONE_DECODER_DEGLITCH_EN to discard pulse pairs shorter than GLITCH_CYC.
module tone_decoder #(
  parameter int CNT_W       = 23,
  parameter int HP0         = 31_888,
  parameter int HP1         = 37_919,
  parameter int HP2         = 28_409,
  parameter int HP3         = 47_801,
  parameter int TOL         = 512,
  parameter int CONFIRM     = 3,
  parameter int SILENCE_CYC = 2_000_000,
  parameter int TICK_CYC    = 6_250_000,
  parameter int GLITCH_CYC  = 64
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSOUND,
  output logic [1:0] oNOTE,
  output logic       oNOTE_VALID,
  output logic       oSILENT,
  output logic       oEVT,
  output logic [2:0] oEVT_CODE,
  output logic [7:0] oEVT_DUR
);

  localparam int c_MW = CNT_W + 1;
  localparam int c_CW = $clog2(CONFIRM + 1);
  localparam logic [c_MW-1:0]       c_TOL       = c_MW'(TOL);
  localparam logic [c_MW-1:0]       c_GLITCH    = c_MW'(GLITCH_CYC);
  localparam logic [3:0][c_MW-1:0]  c_HP        = {c_MW'(HP3), c_MW'(HP2), c_MW'(HP1), c_MW'(HP0)};
  localparam logic [CNT_W-1:0]      c_SIL       = CNT_W'(SILENCE_CYC);
  localparam logic [CNT_W-1:0]      c_TICK_LAST = CNT_W'(TICK_CYC - 1);
  localparam logic [c_CW-1:0]       c_CONF      = c_CW'(CONFIRM);
`ifdef TONE_DECODER_DEGLITCH_EN
  localparam logic c_DEGLITCH = 1'b1;
`else
  localparam logic c_DEGLITCH = 1'b0;
`endif

  localparam logic [1:0] S_SILENT = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCK   = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic             r_prev, r_strobe, r_skip;
  logic [CNT_W-1:0] r_hp_cnt, r_pre;
  logic [7:0]       r_dur, w_dur_now;
  logic [1:0]       r_cand, w_cand_nxt, r_note, w_cls;
  logic [c_CW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_evt, w_evt, w_lock, w_restart, w_known;
  logic [2:0]       r_evt_code, w_evt_code;
  logic [7:0]       r_evt_dur;
  logic [c_MW-1:0]  w_meas;
  logic             w_drop, w_take, w_timeout;

  function automatic logic f_near(input logic [c_MW-1:0] m, input logic [c_MW-1:0] hp);
    logic [c_MW-1:0] d;
    d = (m >= hp) ? (m - hp) : (hp - m);
    return d <= c_TOL;
  endfunction

  // hp_cnt is cleared on a taken strobe, so the half-period is one more than its value
  assign w_meas    = {1'b0, r_hp_cnt} + c_MW'(1);
  assign w_drop    = c_DEGLITCH && (r_state != S_SILENT) && (r_skip || (w_meas < c_GLITCH));
  assign w_take    = r_strobe && !w_drop;
  assign w_timeout = (r_hp_cnt == c_SIL) && !w_take && (r_state != S_SILENT);
  assign w_dur_now = ((r_pre == c_TICK_LAST) && (r_dur != 8'hFF)) ? r_dur + 8'd1 : r_dur;

  always_comb begin
    w_known = 1'b0;
    w_cls   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (f_near(w_meas, c_HP[k])) begin
        w_known = 1'b1;
        w_cls   = 2'(k);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_SILENT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_lock      = 1'b0;
    w_restart   = 1'b0;
    w_evt       = 1'b0;
    w_evt_code  = 3'd4;
    case (r_state)
      S_SILENT: begin
        if (w_take) begin
          w_state_nxt = S_ACQ;
          w_evt       = 1'b1;
          w_cand_nxt  = 2'd0;
          w_cnt_nxt   = '0;
        end
      end
      S_ACQ: begin
        if (w_take) begin
          if (!w_known) begin
            w_cand_nxt = 2'd0;
            w_cnt_nxt  = '0;
          end else if (w_cls == r_cand) begin
            w_cnt_nxt = r_cnt + c_CW'(1);
          end else begin
            w_cand_nxt = w_cls;
            w_cnt_nxt  = c_CW'(1);
          end
          if (w_known && (w_cnt_nxt == c_CONF)) begin
            w_state_nxt = S_LOCK;
            w_lock      = 1'b1;
            w_restart   = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_SILENT;
          w_restart   = 1'b1;
        end
      end
      S_LOCK: begin
        if (w_take) begin
          if (!(w_known && (w_cls == r_note))) begin
            w_state_nxt = S_ACQ;
            w_evt       = 1'b1;
            w_evt_code  = {1'b0, r_note};
            w_cand_nxt  = w_known ? w_cls : 2'd0;
            w_cnt_nxt   = w_known ? c_CW'(1) : '0;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_SILENT;
          w_evt       = 1'b1;
          w_evt_code  = {1'b0, r_note};
          w_restart   = 1'b1;
        end
      end
      default: w_state_nxt = S_SILENT;
    endcase
  end

  always_comb begin
    oSILENT     = (r_state == S_SILENT);
    oNOTE_VALID = (r_state == S_LOCK);
  end

  assign oNOTE     = r_note;
  assign oEVT      = r_evt;
  assign oEVT_CODE = r_evt_code;
  assign oEVT_DUR  = r_evt_dur;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync     <= 2'b00;
      r_prev     <= 1'b0;
      r_strobe   <= 1'b0;
      r_skip     <= 1'b0;
      r_hp_cnt   <= '0;
      r_pre      <= '0;
      r_dur      <= 8'd0;
      r_cand     <= 2'd0;
      r_cnt      <= '0;
      r_note     <= 2'd0;
      r_evt      <= 1'b0;
      r_evt_code <= 3'd0;
      r_evt_dur  <= 8'd0;
    end else begin
      r_sync   <= {r_sync[0], iSOUND};
      r_prev   <= r_sync[1];
      r_strobe <= r_sync[1] ^ r_prev;

      // the edge following a discarded short edge closes the pulse and is discarded too
      if (w_take)                  r_skip <= 1'b0;
      else if (r_strobe && w_drop) r_skip <= ~r_skip;

      if (w_take)                 r_hp_cnt <= '0;
      else if (r_hp_cnt != c_SIL) r_hp_cnt <= r_hp_cnt + CNT_W'(1);

      if (w_restart) begin
        r_pre <= '0;
        r_dur <= 8'd0;
      end else if (r_pre == c_TICK_LAST) begin
        r_pre <= '0;
        r_dur <= w_dur_now;
      end else begin
        r_pre <= r_pre + CNT_W'(1);
      end

      r_cand <= w_cand_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_lock) r_note <= w_cand_nxt;

      r_evt <= w_evt;
      if (w_evt) begin
        r_evt_code <= w_evt_code;
        r_evt_dur  <= w_dur_now;
      end
    end
  end

endmodule
`default_nettype wire
